// File: rtl/button_pkg.sv
// Shared definitions for the button controller: register offsets decoded
// from address bits [3:2] and the bus/byte-lane geometry.
// Optional feature macro: BUTTON_RELEASE_EN (release flags at offset 3).
package button_pkg;

   // Register offsets, as seen on address_in[3:2]
   localparam logic [1:0] REG_STATE   = 2'd0;
   localparam logic [1:0] REG_PRESS   = 2'd1;
   localparam logic [1:0] REG_IRQ_EN  = 2'd2;
   localparam logic [1:0] REG_RELEASE = 2'd3;

   // Bus geometry
   localparam int BUS_WIDTH  = 32;
   localparam int BYTE_WIDTH = 8;

   // Debounce counter width; DEBOUNCE_CYCLES must fit in it
   localparam int COUNT_WIDTH = 16;

   // Byte lane of write_mask_in that governs a given register bit
   function automatic int byte_lane(input int bit_index);
      return bit_index / BYTE_WIDTH;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: two-flop synchronizer, stability counter and the
// debounced level. Also reports the cycle in which the debounced level is
// about to change so the controller can detect edges without extra latency.
module button_debouncer
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_button,
   output logic o_level,
   output logic o_accept
);

   // Counter value on which a still-differing input is accepted
   localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_level;
   logic [COUNT_WIDTH-1:0] r_count;

   logic w_differs;
   logic w_accept;

   // The synchronized input disagrees with the accepted level
   assign w_differs = r_sync2 ^ r_level;

   // Disagreement has lasted long enough: load the new level this cycle
   assign w_accept = w_differs && (r_count == LP_LAST);

   // Bring the asynchronous button level into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_button;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing cycles; accept the level when the count expires
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level <= 1'b0;
         r_count <= '0;
      end else if (!w_differs) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_level <= r_sync2;
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_level  = r_level;
   assign o_accept = w_accept;

endmodule

// File: rtl/button_ctrl.sv
// Memory-mapped button controller: BUTTONCOUNT debounced inputs, sticky
// press flags (write-1-to-clear), interrupt enable mask and a level
// interrupt. Zero-wait-state bus, read data OR-combined (zero when not selected).
// Optional feature macro: BUTTON_RELEASE_EN adds sticky release flags at
// offset 3 which also contribute to the interrupt.
module button_ctrl
   import button_pkg::*;
#(
   parameter int BUTTONCOUNT     = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BUTTONCOUNT-1:0] buttons_in,
   input  logic [31:0]            address_in,
   input  logic                   sel_in,
   input  logic                   read_in,
   output logic [31:0]            read_value_out,
   input  logic [3:0]             write_mask_in,
   input  logic [31:0]            write_value_in,
   output logic                   ready_out,
   output logic                   irq_out
);

   // Debounced levels and the cycle-early change strobes from each channel
   logic [BUTTONCOUNT-1:0] w_level;
   logic [BUTTONCOUNT-1:0] w_accept;

   // Edge events, aligned with the cycle in which the debounced level changes
   logic [BUTTONCOUNT-1:0] w_rise;

   // Per-bit write enable derived from the byte lane that holds the bit
   logic [BUTTONCOUNT-1:0] w_lane_en;

   // Register write decode
   logic                   w_wr_press;
   logic                   w_wr_irq_en;
   logic [BUTTONCOUNT-1:0] w_press_clr;
   logic [BUTTONCOUNT-1:0] w_irq_en_we;

   // Sticky flags, enable mask and registered interrupt
   logic [BUTTONCOUNT-1:0] r_press;
   logic [BUTTONCOUNT-1:0] r_irq_en;
   logic                   r_irq;

   // Flags that can raise the interrupt
   logic [BUTTONCOUNT-1:0] w_pending;

   // Combinational read data
   logic [BUS_WIDTH-1:0]   w_read_data;

`ifdef BUTTON_RELEASE_EN
   logic                   w_wr_release;
   logic [BUTTONCOUNT-1:0] w_fall;
   logic [BUTTONCOUNT-1:0] w_release_clr;
   logic [BUTTONCOUNT-1:0] r_release;
`endif

   // Inputs that the register map does not decode; read data is
   // combinational, so the read strobe carries no extra information
   logic [66:0] w_unused_bits;
   assign w_unused_bits = {read_in, address_in[31:4], address_in[1:0],
                           write_value_in, write_mask_in};

   // Per-button channels and per-bit decode
   generate
      for (genvar gi = 0; gi < BUTTONCOUNT; gi++) begin : g_button
         button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debouncer (
            .clk      (clk),
            .reset    (reset),
            .i_button (buttons_in[gi]),
            .o_level  (w_level[gi]),
            .o_accept (w_accept[gi])
         );

         // An accepted change from a low level is a press
         assign w_rise[gi]    = w_accept[gi] & ~w_level[gi];
         assign w_lane_en[gi] = write_mask_in[byte_lane(gi)];

`ifdef BUTTON_RELEASE_EN
         // An accepted change from a high level is a release
         assign w_fall[gi] = w_accept[gi] & w_level[gi];
`endif
      end
   endgenerate

   // Address decode for the writable registers
   assign w_wr_press  = sel_in && (address_in[3:2] == REG_PRESS);
   assign w_wr_irq_en = sel_in && (address_in[3:2] == REG_IRQ_EN);

   // W1C mask for PRESS, limited to enabled byte lanes
   assign w_press_clr = w_wr_press ? (write_value_in[BUTTONCOUNT-1:0] & w_lane_en)
                                   : '0;

   // Bits of IRQ_EN that take the write data this cycle
   assign w_irq_en_we = w_wr_irq_en ? w_lane_en : '0;

`ifdef BUTTON_RELEASE_EN
   assign w_wr_release  = sel_in && (address_in[3:2] == REG_RELEASE);
   assign w_release_clr = w_wr_release ? (write_value_in[BUTTONCOUNT-1:0] & w_lane_en)
                                       : '0;
   assign w_pending     = (r_press | r_release) & r_irq_en;
`else
   assign w_pending     = r_press & r_irq_en;
`endif

   // Sticky press flags: a new press in the same cycle as a clear keeps the bit set
   always_ff @(posedge clk) begin
      if (reset) begin
         r_press <= '0;
      end else begin
         r_press <= (r_press & ~w_press_clr) | w_rise;
      end
   end

`ifdef BUTTON_RELEASE_EN
   // Sticky release flags, same set-wins rule as the press flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_release <= '0;
      end else begin
         r_release <= (r_release & ~w_release_clr) | w_fall;
      end
   end
`endif

   // Interrupt enable mask, byte-lane write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_en <= '0;
      end else begin
         r_irq_en <= (r_irq_en & ~w_irq_en_we)
                   | (write_value_in[BUTTONCOUNT-1:0] & w_irq_en_we);
      end
   end

   // Level interrupt, registered one cycle behind the flags and mask
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_pending;
      end
   end

   // Read mux; unselected block drives zero so outputs can be OR-combined
   always_comb begin
      w_read_data = '0;
      if (sel_in) begin
         case (address_in[3:2])
            REG_STATE:   w_read_data = BUS_WIDTH'(w_level);
            REG_PRESS:   w_read_data = BUS_WIDTH'(r_press);
            REG_IRQ_EN:  w_read_data = BUS_WIDTH'(r_irq_en);
`ifdef BUTTON_RELEASE_EN
            REG_RELEASE: w_read_data = BUS_WIDTH'(r_release);
`else
            REG_RELEASE: w_read_data = '0;
`endif
            default:     w_read_data = '0;
         endcase
      end
   end

   assign read_value_out = w_read_data;
   assign ready_out      = sel_in;
   assign irq_out        = r_irq;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl (BUTTONCOUNT=4, DEBOUNCE_CYCLES=4).
// Directed scenarios plus a randomized run checked against a window-based
// reference model. Honours BUTTON_RELEASE_EN when defined.
module tb_button_ctrl;

   localparam int BC = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [BC-1:0] buttons_in;
   logic [31:0]   address_in;
   logic          sel_in;
   logic          read_in;
   logic [31:0]   read_value_out;
   logic [3:0]    write_mask_in;
   logic [31:0]   write_value_in;
   logic          ready_out;
   logic          irq_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   button_ctrl #(
      .BUTTONCOUNT     (BC),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .buttons_in     (buttons_in),
      .address_in     (address_in),
      .sel_in         (sel_in),
      .read_in        (read_in),
      .read_value_out (read_value_out),
      .write_mask_in  (write_mask_in),
      .write_value_in (write_value_in),
      .ready_out      (ready_out),
      .irq_out        (irq_out)
   );

   // Reference model. A debounced bit flips when the DC raw samples ending
   // two clocks ago (synchronizer delay) all differ from the current level.
   logic [BC-1:0] m_hist [0:DC+1];
   logic [BC-1:0] m_level, m_press, m_en, m_rel;
   logic          m_irq;

   always @(posedge clk) begin : model
      logic [BC-1:0] nl, rise, clr_p, pend;
      logic          all_diff;
`ifdef BUTTON_RELEASE_EN
      logic [BC-1:0] fall, clr_r;
      pend = (m_press | m_rel) & m_en;
`else
      pend = m_press & m_en;
`endif
      if (reset) begin
         for (int k = 0; k <= DC + 1; k++) m_hist[k] = '0;
         m_level = '0; m_press = '0; m_en = '0; m_rel = '0; m_irq = 1'b0;
      end else begin
         for (int k = DC + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = buttons_in;
         nl = m_level;
         for (int b = 0; b < BC; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= DC + 1; k++)
               if (m_hist[k][b] == m_level[b]) all_diff = 1'b0;
            if (all_diff) nl[b] = ~m_level[b];
         end
         rise  = nl & ~m_level;
         clr_p = (sel_in && address_in[3:2] == 2'd1 && write_mask_in[0])
                 ? write_value_in[BC-1:0] : '0;
         m_press = (m_press & ~clr_p) | rise;
         if (sel_in && address_in[3:2] == 2'd2 && write_mask_in[0])
            m_en = write_value_in[BC-1:0];
`ifdef BUTTON_RELEASE_EN
         fall  = ~nl & m_level;
         clr_r = (sel_in && address_in[3:2] == 2'd3 && write_mask_in[0])
                 ? write_value_in[BC-1:0] : '0;
         m_rel = (m_rel & ~clr_r) | fall;
`endif
         m_irq   = |pend;
         m_level = nl;
      end
   end

   task automatic set_idle();
      sel_in = 1'b0; read_in = 1'b0; address_in = '0;
      write_mask_in = '0; write_value_in = '0;
   endtask

   task automatic bus_read(input logic [1:0] off, output logic [31:0] v);
      sel_in = 1'b1; read_in = 1'b1; address_in = {28'd0, off, 2'b00};
      write_mask_in = '0;
      #1;
      v = read_value_out;
      set_idle();
   endtask

   task automatic bus_write(input logic [1:0] off, input logic [3:0] mask,
                            input logic [31:0] data);
      sel_in = 1'b1; read_in = 1'b0; address_in = {28'd0, off, 2'b00};
      write_mask_in = mask; write_value_in = data;
      @(negedge clk);
      set_idle();
   endtask

   // Release all buttons, let them settle, clear flags and enables
   task automatic cleanup();
      buttons_in = '0;
      repeat (DC + 4) @(negedge clk);
      bus_write(2'd2, 4'hF, 32'h0);
      bus_write(2'd1, 4'hF, 32'hF);
      bus_write(2'd3, 4'hF, 32'hF);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1; buttons_in = '0; set_idle();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int r = 0; r < 4; r++) begin
         bus_read(2'(r), v);
         total++;
         if (v !== 32'h0) begin
            bad++; $display("FAIL reset_reg%0d: got %h expected %h", r, v, 32'h0);
         end
      end
      total++;
      if (irq_out !== 1'b0) begin
         bad++; $display("FAIL reset_irq: got %b expected 0", irq_out);
      end
      @(negedge clk);
   endtask

   task automatic test_press();
      logic [31:0] v;
      buttons_in = 4'b0001;
      repeat (5) @(negedge clk);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL press_state_early: got %h expected %h", v, 32'h0);
      end
      @(negedge clk);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h1) begin
         bad++; $display("FAIL press_state: got %h expected %h", v, 32'h1);
      end
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h1) begin
         bad++; $display("FAIL press_flag: got %h expected %h", v, 32'h1);
      end
      sel_in = 1'b0; address_in = 32'h0; #1;
      total++;
      if (read_value_out !== 32'h0 || ready_out !== 1'b0) begin
         bad++; $display("FAIL unselected_bus: got data %h ready %b expected 0 0",
                         read_value_out, ready_out);
      end
      sel_in = 1'b1; #1;
      total++;
      if (read_value_out !== 32'h1 || ready_out !== 1'b1) begin
         bad++; $display("FAIL selected_bus: got data %h ready %b expected 1 1",
                         read_value_out, ready_out);
      end
      set_idle();
      cleanup();
   endtask

   task automatic test_glitch();
      logic [31:0] v;
      buttons_in = 4'b0010;
      repeat (3) @(negedge clk);
      buttons_in = 4'b0000;
      repeat (10) @(negedge clk);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL glitch_state: got %h expected %h", v, 32'h0);
      end
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL glitch_press: got %h expected %h", v, 32'h0);
      end
      // A pulse lasting exactly DEBOUNCE_CYCLES is accepted
      buttons_in = 4'b0010;
      repeat (DC) @(negedge clk);
      buttons_in = 4'b0000;
      repeat (10) @(negedge clk);
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h2) begin
         bad++; $display("FAIL min_pulse_press: got %h expected %h", v, 32'h2);
      end
      cleanup();
   endtask

   task automatic test_w1c();
      logic [31:0] v;
      buttons_in = 4'b0011;
      repeat (6) @(negedge clk);
      buttons_in = 4'b0000;
      repeat (8) @(negedge clk);
      bus_write(2'd1, 4'b0000, 32'h3);
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h3) begin
         bad++; $display("FAIL w1c_nomask: got %h expected %h", v, 32'h3);
      end
      bus_write(2'd1, 4'b0001, 32'h1);
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h2) begin
         bad++; $display("FAIL w1c_bit0: got %h expected %h", v, 32'h2);
      end
      bus_write(2'd2, 4'b0010, 32'hF);
      bus_read(2'd2, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL irq_en_wrong_lane: got %h expected %h", v, 32'h0);
      end
      bus_write(2'd2, 4'b0001, 32'h5);
      bus_read(2'd2, v);
      total++;
      if (v !== 32'h5) begin
         bad++; $display("FAIL irq_en_write: got %h expected %h", v, 32'h5);
      end
      bus_write(2'd0, 4'hF, 32'hF);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL state_readonly: got %h expected %h", v, 32'h0);
      end
      cleanup();
   endtask

   task automatic test_set_wins();
      logic [31:0] v;
      buttons_in = 4'b0100;
      repeat (5) @(negedge clk);
      // This write spans the clock edge on which bit 2 is accepted
      bus_write(2'd1, 4'b0001, 32'h4);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h4) begin
         bad++; $display("FAIL setwins_state: got %h expected %h", v, 32'h4);
      end
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h4) begin
         bad++; $display("FAIL setwins_press: got %h expected %h", v, 32'h4);
      end
      bus_write(2'd1, 4'b0001, 32'h4);
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL setwins_later_clear: got %h expected %h", v, 32'h0);
      end
      cleanup();
   endtask

   task automatic test_irq();
      bus_write(2'd2, 4'b0001, 32'h1);
      buttons_in = 4'b0001;
      repeat (6) @(negedge clk);
      total++;
      if (irq_out !== 1'b0) begin
         bad++; $display("FAIL irq_same_cycle_as_flag: got %b expected 0", irq_out);
      end
      @(negedge clk);
      total++;
      if (irq_out !== 1'b1) begin
         bad++; $display("FAIL irq_assert: got %b expected 1", irq_out);
      end
      bus_write(2'd1, 4'b0001, 32'h1);
      total++;
      if (irq_out !== 1'b1) begin
         bad++; $display("FAIL irq_hold_on_clear: got %b expected 1", irq_out);
      end
      @(negedge clk);
      total++;
      if (irq_out !== 1'b0) begin
         bad++; $display("FAIL irq_deassert: got %b expected 0", irq_out);
      end
      cleanup();
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      logic [31:0] exp_rel;
      buttons_in = 4'b1000;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h0) begin
         bad++; $display("FAIL midreset_state_early: got %h expected %h", v, 32'h0);
      end
      @(negedge clk);
      bus_read(2'd0, v);
      total++;
      if (v !== 32'h8) begin
         bad++; $display("FAIL midreset_state: got %h expected %h", v, 32'h8);
      end
      bus_read(2'd1, v);
      total++;
      if (v !== 32'h8) begin
         bad++; $display("FAIL midreset_press: got %h expected %h", v, 32'h8);
      end
      buttons_in = 4'b0000;
      repeat (8) @(negedge clk);
`ifdef BUTTON_RELEASE_EN
      exp_rel = 32'h8;
`else
      exp_rel = 32'h0;
`endif
      bus_read(2'd3, v);
      total++;
      if (v !== exp_rel) begin
         bad++; $display("FAIL release_flag: got %h expected %h", v, exp_rel);
      end
      cleanup();
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [31:0] exp;
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), v);
            case (r)
               0:       exp = {28'd0, m_level};
               1:       exp = {28'd0, m_press};
               2:       exp = {28'd0, m_en};
               default: exp = {28'd0, m_rel};
            endcase
            total++;
            if (v !== exp) begin
               bad++; $display("FAIL random_reg%0d cycle %0d: got %h expected %h",
                               r, i, v, exp);
            end
         end
         total++;
         if (irq_out !== m_irq) begin
            bad++; $display("FAIL random_irq cycle %0d: got %b expected %b",
                            i, irq_out, m_irq);
         end
         if ($urandom_range(0, 3) == 0)
            buttons_in = buttons_in ^ BC'(1 << $urandom_range(0, BC - 1));
         reset = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) == 0) begin
            sel_in = 1'b1;
            address_in = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            write_mask_in = 4'($urandom_range(0, 15));
            write_value_in = $urandom;
         end
         @(negedge clk);
         set_idle();
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_w1c();
      test_set_wins();
      test_irq();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
